// File: rtl/spi_pkg.sv
// spi_pkg: shared widths for the SPI command path.
// Consumed by spi_cmd_arbiter and its bench.
package spi_pkg;
  localparam int SPI_DWIDTH = 8;
  localparam int SPI_AWIDTH = 8;
  localparam int SPI_SWIDTH = 2;
endpackage

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: grants command words from NREQ requesters to one SPI master.
// Define SPI_ARB_PRIO_EN to give requester 0 fixed priority over the rest.
module spi_cmd_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DWIDTH = SPI_DWIDTH,
  parameter int AWIDTH = SPI_AWIDTH,
  parameter int S_ADDR_WIDTH = SPI_SWIDTH,
  localparam int CW = S_ADDR_WIDTH + 1 + 2 + AWIDTH + DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*CW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DWIDTH-1:0]    rsp_rdata,
  input  logic [1:0]           cfg_mode,
  input  logic                 driver_read,
  input  logic [DWIDTH-1:0]    spi_slv_read_data,
  output logic                 master_en,
  output logic [CW-1:0]        driver_data,
  output logic [1:0]           driver_cfg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WR_BIT = DWIDTH + AWIDTH + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     data_q, data_d;
  logic              en_q, en_d;
  logic [1:0]        cfg_q, cfg_d;
  logic [NREQ-1:0]   rdy_q, rdy_d;
  logic [NREQ-1:0]   rsp_q, rsp_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     own_q, own_d;
  logic              fl_vld_q, fl_vld_d;
  logic              fl_wr_q, fl_wr_d;
  logic [PW-1:0]     fl_own_q, fl_own_d;

  logic [NREQ-1:0]   elig;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic              load;
  logic              done;

  // A requester whose ready pulse is still out has not yet dropped its
  // old word, so it must not be granted twice.
  assign elig = req_valid & ~rdy_q;

  always_comb begin : arb
    int c;
    c = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef SPI_ARB_PRIO_EN
    if (elig[0]) begin
      gnt_vld = 1'b1;
    end
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(rr_q) + k) % NREQ;
      if (!gnt_vld && c != 0 && elig[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(c);
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(rr_q) + k) % NREQ;
      if (!gnt_vld && elig[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(c);
      end
    end
`endif
  end

  assign done = driver_read && (state_q != IDLE);
  assign load = gnt_vld &&
    ((state_q == IDLE) || (state_q == ACTIVE && driver_read));

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    en_d     = en_q;
    cfg_d    = cfg_q;
    rdy_d    = '0;
    rsp_d    = '0;
    rdata_d  = rdata_q;
    rr_d     = rr_q;
    own_d    = own_q;
    fl_vld_d = fl_vld_q;
    fl_wr_d  = fl_wr_q;
    fl_own_d = fl_own_q;

    if (done && fl_vld_q && !fl_wr_q) begin
      rsp_d[fl_own_q] = 1'b1;
      rdata_d = spi_slv_read_data;
    end

    if (load) begin
      data_d = req_data[int'(gnt_idx)*CW +: CW];
      own_d = gnt_idx;
      rdy_d[gnt_idx] = 1'b1;
`ifdef SPI_ARB_PRIO_EN
      if (gnt_idx != '0) rr_d = gnt_idx;
`else
      rr_d = gnt_idx;
`endif
    end

    unique case (state_q)
      IDLE: begin
        cfg_d = cfg_mode;
        if (load) begin
          en_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (driver_read) begin
          fl_vld_d = 1'b1;
          fl_wr_d = data_q[WR_BIT];
          fl_own_d = own_q;
          if (!load) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (driver_read) begin
          fl_vld_d = 1'b0;
          en_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d = 1'b0;
        fl_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      en_q     <= 1'b0;
      cfg_q    <= 2'b00;
      rdy_q    <= '0;
      rsp_q    <= '0;
      rdata_q  <= '0;
      rr_q     <= PW'(NREQ - 1);
      own_q    <= '0;
      fl_vld_q <= 1'b0;
      fl_wr_q  <= 1'b0;
      fl_own_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      en_q     <= en_d;
      cfg_q    <= cfg_d;
      rdy_q    <= rdy_d;
      rsp_q    <= rsp_d;
      rdata_q  <= rdata_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      fl_vld_q <= fl_vld_d;
      fl_wr_q  <= fl_wr_d;
      fl_own_q <= fl_own_d;
    end
  end

  assign req_ready   = rdy_q;
  assign rsp_valid   = rsp_q;
  assign rsp_rdata   = rdata_q;
  assign master_en   = en_q;
  assign driver_data = data_q;
  assign driver_cfg  = cfg_q;

endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, default 2, number of requesters (2..4); DWIDTH, default from spi_pkg, data width; AWIDTH, default from spi_pkg, address width; S_ADDR_WIDTH, default from spi_pkg, slave-select width.
REQ-002 SHALL define CW = S_ADDR_WIDTH+1+2+AWIDTH+DWIDTH; word layout MSB..LSB: {SS, WR_EN, SIZE[1:0], ADDR, WDATA}.
REQ-003 SHALL have ports:
clk  in  1  global clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  requester i has a command word
req_data  in  NREQ*CW  command word of requester i at [i*CW+:CW]
req_ready  out  NREQ  one-cycle pulse, word of requester i accepted
rsp_valid  out  NREQ  one-cycle pulse, read data for requester i valid
rsp_rdata  out  DWIDTH  read data, valid with rsp_valid
cfg_mode  in  2  SPI mode request
driver_read  in  1  master consumed presented word and completed previous one
spi_slv_read_data  in  DWIDTH  slave read data, valid while driver_read=1
master_en  out  1  enables SPI master
driver_data  out  CW  command word presented to master
driver_cfg  out  2  SPI mode applied to master

Function
REQ-004 SHALL implement FSM states IDLE, ACTIVE, DRAIN.
REQ-005 IDLE: master_en=0; if any req_valid, SHALL grant one requester, register its word into driver_data, pulse its req_ready, set master_en=1 and enter ACTIVE on the next edge.
REQ-006 ACTIVE: driver_data and master_en SHALL be held stable until driver_read=1.
REQ-007 On driver_read=1 in ACTIVE, the presented word SHALL move to an in-flight register {owner, WR_EN, valid}; the previous in-flight entry SHALL complete.
REQ-008 Completing in-flight entry with WR_EN=0 SHALL pulse rsp_valid[owner] and drive rsp_rdata=spi_slv_read_data, registered, 1 cycle after driver_read; WR_EN=1 completion SHALL produce no response.
REQ-009 On driver_read=1 in ACTIVE with any req_valid, SHALL grant and load the next word in the same edge, remaining in ACTIVE (back-to-back, no bubble).
REQ-010 On driver_read=1 in ACTIVE with no req_valid, SHALL enter DRAIN holding driver_data.
REQ-011 DRAIN: on driver_read=1 SHALL complete the in-flight entry, clear it, set master_en=0, enter IDLE; new req_valid in DRAIN SHALL wait until IDLE.
REQ-012 Default arbitration SHALL be round-robin: search starts at requester after the last granted, wrapping from NREQ-1 to 0.
REQ-013 At most one req_ready bit SHALL be high per cycle; req_ready SHALL never pulse for a requester with req_valid=0.
REQ-014 driver_cfg SHALL load cfg_mode only in IDLE; cfg_mode changes in ACTIVE/DRAIN SHALL be ignored until IDLE.
REQ-015 driver_read=1 in IDLE SHALL be ignored.

Reset
REQ-016 On rst_n=0, immediately: state=IDLE, master_en=0, driver_data=0, driver_cfg=2'b00, req_ready=0, rsp_valid=0, rsp_rdata=0, in-flight cleared, round-robin pointer=NREQ-1 (requester 0 first).
REQ-017 Reset mid-operation SHALL discard accepted and in-flight words with no response issued.

Configuration
REQ-018 With SPI_ARB_PRIO_EN defined, requester 0 SHALL win whenever its req_valid=1; others round-robin among themselves.
REQ-019 Without SPI_ARB_PRIO_EN, all requesters SHALL be pure round-robin per REQ-012.

Verification
REQ-020 NREQ=2, req0 write ADDR=0x10 WDATA=0xA5, driver_read after 8 cycles, twice -> req_ready[0] once, master_en 1 then 0, no rsp_valid.
REQ-021 req1 read ADDR=0x04, slave returns 0x3C on completing driver_read -> rsp_valid[1] one cycle later, rsp_rdata=0x3C.
REQ-022 req0 and req1 valid continuously, 6 words -> grant order 0,1,0,1,0,1 without macro; with SPI_ARB_PRIO_EN all req0 first.
REQ-023 cfg_mode=2'b11 while ACTIVE -> driver_cfg stays 2'b00 until IDLE, then 2'b11.
REQ-024 rst_n low in ACTIVE with read in flight -> master_en=0 immediately, no rsp_valid after release.
REQ-025 driver_read=1 in IDLE with no requests -> no state change, all outputs at reset values.
